// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: program-counter sequencer fed by EX-stage control-flow
// resolution. Loads redirect targets, flushes younger IF/ID work for a fixed
// window, halts fetch on a misaligned target and keeps branch statistics.
module branch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2,   // legal range 1..7
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jal,
   input  logic             ex_is_jalr,
   input  logic             take_branch,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic [31:0]      ex_rs1_val,
   output logic [31:0]      pc,
   output logic             pc_valid,
   output logic             flush,
   output logic             redirect,
   output logic [31:0]      redirect_target,
   output logic             misalign_trap,
   output logic [31:0]      trap_pc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2, TRAP = 2'd3} state_t;

   // The flush counter is loaded with the remaining cycles after the redirect cycle.
   localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_reg, state_next;
   logic [2:0]       fcnt_reg, fcnt_next;
   logic [31:0]      pc_reg, pc_next;
   logic             pc_valid_reg, pc_valid_next;
   logic             flush_reg, flush_next;
   logic             redirect_reg, redirect_next;
   logic [31:0]      redirect_target_reg, redirect_target_next;
   logic             trap_reg, trap_next;
   logic [31:0]      trap_pc_reg, trap_pc_next;
   logic [CNT_W-1:0] branch_count_reg, branch_count_next;
   logic [CNT_W-1:0] taken_count_reg, taken_count_next;

   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        req;
   logic        misaligned;
   logic        cond_branch;

   // JALR wins over JAL/branch; JALR clears bit0 before the alignment test.
   assign target      = ex_is_jalr ? ((ex_rs1_val + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
   assign misaligned  = (target[1:0] != 2'b00);
   assign req         = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & take_branch));
   assign cond_branch = ex_valid & ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
   assign pc_inc      = stall ? pc_reg : (pc_reg + 32'd4);

   // State register together with all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= BOOT;
         fcnt_reg            <= 3'd0;
         pc_reg              <= RESET_PC;
         pc_valid_reg        <= 1'b0;
         flush_reg           <= 1'b0;
         redirect_reg        <= 1'b0;
         redirect_target_reg <= 32'd0;
         trap_reg            <= 1'b0;
         trap_pc_reg         <= 32'd0;
         branch_count_reg    <= '0;
         taken_count_reg     <= '0;
      end else begin
         state_reg           <= state_next;
         fcnt_reg            <= fcnt_next;
         pc_reg              <= pc_next;
         pc_valid_reg        <= pc_valid_next;
         flush_reg           <= flush_next;
         redirect_reg        <= redirect_next;
         redirect_target_reg <= redirect_target_next;
         trap_reg            <= trap_next;
         trap_pc_reg         <= trap_pc_next;
         branch_count_reg    <= branch_count_next;
         taken_count_reg     <= taken_count_next;
      end
   end

   // Next-state selection.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BOOT:    state_next = RUN;
         RUN: begin
            if (req) begin
               if (misaligned)             state_next = TRAP;
               else if (FLUSH_CYCLES > 1)  state_next = FLUSH;
               else                        state_next = RUN;
            end
         end
         FLUSH:   if (fcnt_reg == 3'd0) state_next = RUN;
         TRAP:    state_next = TRAP;
         default: state_next = BOOT;
      endcase
   end

   // Next values of the registered outputs; TRAP holds everything.
   always_comb begin
      fcnt_next            = fcnt_reg;
      pc_next              = pc_reg;
      pc_valid_next        = pc_valid_reg;
      flush_next           = flush_reg;
      redirect_next        = redirect_reg;
      redirect_target_next = redirect_target_reg;
      trap_next            = trap_reg;
      trap_pc_next         = trap_pc_reg;
      branch_count_next    = branch_count_reg;
      taken_count_next     = taken_count_reg;
      case (state_reg)
         BOOT: pc_valid_next = 1'b1;
         RUN: begin
            if (cond_branch && (branch_count_reg != CNT_MAX))
               branch_count_next = branch_count_reg + CNT_ONE;
            if (cond_branch && take_branch && !misaligned && (taken_count_reg != CNT_MAX))
               taken_count_next = taken_count_reg + CNT_ONE;
            if (req && misaligned) begin
               trap_next     = 1'b1;
               trap_pc_next  = ex_pc;
               pc_valid_next = 1'b0;
               redirect_next = 1'b0;
               flush_next    = 1'b0;
            end else if (req) begin
               pc_next              = target;
               redirect_next        = 1'b1;
               redirect_target_next = target;
               flush_next           = 1'b1;
               fcnt_next            = FLUSH_LOAD;
            end else begin
               pc_next       = pc_inc;
               redirect_next = 1'b0;
               flush_next    = 1'b0;
            end
         end
         FLUSH: begin
            // EX inputs are squashed here; stall only holds the PC.
            pc_next       = pc_inc;
            redirect_next = 1'b0;
            if (fcnt_reg == 3'd0) flush_next = 1'b0;
            else                  fcnt_next  = fcnt_reg - 3'd1;
         end
         default: ;
      endcase
   end

   assign pc              = pc_reg;
   assign pc_valid        = pc_valid_reg;
   assign flush           = flush_reg;
   assign redirect        = redirect_reg;
   assign redirect_target = redirect_target_reg;
   assign misalign_trap   = trap_reg;
   assign trap_pc         = trap_pc_reg;
   assign branch_count    = branch_count_reg;
   assign taken_count     = taken_count_reg;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a cycle model pushes expected
// outputs when inputs are driven; they are popped and compared after the edge.
// A second instance with 4-bit counters exercises counter saturation.
module tb_branch_redirect_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          FC     = 2;

   logic        clk = 1'b0;
   logic        rst, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, take_branch;
   logic [31:0] ex_pc, ex_imm, ex_rs1_val;

   logic [31:0] pc, redirect_target, trap_pc, branch_count, taken_count;
   logic        pc_valid, flush, redirect, misalign_trap;

   logic [31:0] s_pc, s_redirect_target, s_trap_pc;
   logic        s_pc_valid, s_flush, s_redirect, s_misalign_trap;
   logic [3:0]  s_branch_count, s_taken_count;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .take_branch(take_branch), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val),
      .pc(pc), .pc_valid(pc_valid), .flush(flush), .redirect(redirect),
      .redirect_target(redirect_target), .misalign_trap(misalign_trap), .trap_pc(trap_pc),
      .branch_count(branch_count), .taken_count(taken_count));

   branch_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .take_branch(take_branch), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val),
      .pc(s_pc), .pc_valid(s_pc_valid), .flush(s_flush), .redirect(s_redirect),
      .redirect_target(s_redirect_target), .misalign_trap(s_misalign_trap), .trap_pc(s_trap_pc),
      .branch_count(s_branch_count), .taken_count(s_taken_count));

   typedef struct packed {
      logic [31:0] pc;
      logic        pv, fl, rd;
      logic [31:0] rt;
      logic        tr;
      logic [31:0] tp, bc, tc;
      logic [3:0]  bc4, tc4;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state
   typedef enum int {M_BOOT, M_RUN, M_FLUSH, M_TRAP} mstate_t;
   mstate_t     m_state = M_BOOT;
   int          m_fc = 0;
   logic [31:0] m_pc = '0, m_rt = '0, m_tp = '0, m_bc = '0, m_tc = '0;
   logic        m_pv = 1'b0, m_fl = 1'b0, m_rd = 1'b0, m_tr = 1'b0;
   logic [3:0]  m_bc4 = '0, m_tc4 = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_step();
      logic [31:0] tgt;
      logic        req, mis, cb;
      exp_t        e;
      if (rst) begin
         m_state = M_BOOT; m_fc = 0; m_pc = RST_PC; m_pv = 0; m_fl = 0; m_rd = 0;
         m_rt = 0; m_tr = 0; m_tp = 0; m_bc = 0; m_tc = 0; m_bc4 = 0; m_tc4 = 0;
      end else begin
         case (m_state)
            M_BOOT: begin m_pv = 1; m_state = M_RUN; end
            M_RUN: begin
               if (ex_is_jalr) tgt = (ex_rs1_val + ex_imm) & 32'hFFFF_FFFE;
               else            tgt = ex_pc + ex_imm;
               mis = (tgt[1:0] != 2'b00);
               req = ex_valid && (ex_is_jalr || ex_is_jal || (ex_is_branch && take_branch));
               cb  = ex_valid && ex_is_branch && !ex_is_jal && !ex_is_jalr;
               if (cb) begin
                  if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
                  if (m_bc4 != 4'hF) m_bc4 = m_bc4 + 1;
                  if (take_branch && !mis) begin
                     if (m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 1;
                     if (m_tc4 != 4'hF) m_tc4 = m_tc4 + 1;
                  end
               end
               if (req && mis) begin
                  m_tr = 1; m_tp = ex_pc; m_pv = 0; m_rd = 0; m_fl = 0; m_state = M_TRAP;
               end else if (req) begin
                  m_pc = tgt; m_rd = 1; m_rt = tgt; m_fl = 1; m_fc = FC - 1;
                  m_state = (FC > 1) ? M_FLUSH : M_RUN;
               end else begin
                  if (!stall) m_pc = m_pc + 4;
                  m_rd = 0; m_fl = 0;
               end
            end
            M_FLUSH: begin
               m_rd = 0;
               if (!stall) m_pc = m_pc + 4;
               if (m_fc == 0) begin m_fl = 0; m_state = M_RUN; end
               else m_fc = m_fc - 1;
            end
            default: ;
         endcase
      end
      e = '{pc: m_pc, pv: m_pv, fl: m_fl, rd: m_rd, rt: m_rt, tr: m_tr,
            tp: m_tp, bc: m_bc, tc: m_tc, bc4: m_bc4, tc4: m_tc4};
      sb_q.push_back(e);
   endtask

   // One clock: push expectation, take the edge, pop and compare.
   task automatic tick();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check("pc",        pc,                     e.pc);
         check("pc_valid",  {31'd0, pc_valid},      {31'd0, e.pv});
         check("flush",     {31'd0, flush},         {31'd0, e.fl});
         check("redirect",  {31'd0, redirect},      {31'd0, e.rd});
         check("rtarget",   redirect_target,        e.rt);
         check("trap",      {31'd0, misalign_trap}, {31'd0, e.tr});
         check("trap_pc",   trap_pc,                e.tp);
         check("br_cnt",    branch_count,           e.bc);
         check("tk_cnt",    taken_count,            e.tc);
         check("br_cnt4",   {28'd0, s_branch_count}, {28'd0, e.bc4});
         check("tk_cnt4",   {28'd0, s_taken_count},  {28'd0, e.tc4});
      end
      $display("[TB] cyc %0d rst=%b stall=%b exv=%b pc=%h pv=%b fl=%b rd=%b trap=%b bc=%0d tc=%0d bc4=%0d tc4=%0d",
               cyc, rst, stall, ex_valid, pc, pc_valid, flush, redirect, misalign_trap,
               branch_count, taken_count, s_branch_count, s_taken_count);
   endtask

   task automatic idle();
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; take_branch = 0;
      stall = 0;
   endtask

   task automatic drive(input logic br, input logic jal, input logic jalr, input logic tk,
                        input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rs1);
      ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr; take_branch = tk;
      ex_pc = epc; ex_imm = imm; ex_rs1_val = rs1;
   endtask

   initial begin
      rst = 1; ex_pc = 0; ex_imm = 0; ex_rs1_val = 0;
      idle();
      // Reset values
      tick(); tick();
      check("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
      rst = 0;
      // Boot: pc=0 valid, then 4, then 8
      tick();
      check("boot_pc", pc, 32'h0);
      check("boot_pv", {31'd0, pc_valid}, 32'd1);
      tick(); tick();
      check("boot_pc8", pc, 32'h8);

      // Taken BEQ 0x100 + 0x40
      drive(1, 0, 0, 1, 32'h100, 32'h40, 32'h0);
      tick();
      check("beq_pc", pc, 32'h140);
      check("beq_rd", {31'd0, redirect}, 32'd1);
      idle();
      tick();
      check("beq_fl2", {31'd0, flush}, 32'd1);
      check("beq_rd_pulse", {31'd0, redirect}, 32'd0);
      tick();
      check("beq_fl_end", {31'd0, flush}, 32'd0);
      check("beq_cnt", taken_count, 32'd1);

      // Not-taken branch with stall: pc held
      drive(1, 0, 0, 0, 32'h144, 32'h8, 32'h0);
      stall = 1;
      tick();
      check("nt_pc_hold", pc, 32'h148);
      check("nt_bcnt", branch_count, 32'd2);
      idle();
      tick();

      // Redirect presented during flush is squashed
      drive(1, 0, 0, 1, 32'h200, 32'h20, 32'h0);
      tick();
      drive(1, 0, 0, 1, 32'h300, 32'h80, 32'h0);
      tick();
      check("sq_pc", pc, 32'h224);
      idle();
      tick();
      check("sq_pc2", pc, 32'h228);

      // JAL to the top of the address space, then wrap
      drive(0, 1, 0, 0, 32'h10, 32'hFFFF_FFEC, 32'h0);
      tick();
      check("wrap_top", pc, 32'hFFFF_FFFC);
      idle();
      tick();
      check("wrap_zero", pc, 32'h0);
      tick();

      // Saturation of the 4-bit counters
      for (int i = 0; i < 18; i++) begin
         drive(1, 0, 0, 1, 32'h1000 + 32'(i) * 32'h40, 32'h80, 32'h0);
         tick();
         idle();
         tick(); tick();
      end
      check("sat_bc4", {28'd0, s_branch_count}, 32'd15);
      check("sat_tc4", {28'd0, s_taken_count}, 32'd15);

      // Random aligned traffic, mixed flags and stalls
      for (int i = 0; i < 60; i++) begin
         ex_valid     = 1'($urandom);
         ex_is_branch = 1'($urandom);
         ex_is_jal    = ($urandom_range(0, 3) == 0);
         ex_is_jalr   = ($urandom_range(0, 3) == 0);
         take_branch  = 1'($urandom);
         stall        = ($urandom_range(0, 3) == 0);
         ex_pc        = $urandom & 32'hFFFF_FFFC;
         ex_imm       = $urandom & 32'hFFFF_FFFC;
         ex_rs1_val   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
         tick();
      end
      idle();
      tick(); tick(); tick();

      // JALR aligned: (0x2001+0x10)&~1 = 0x2010
      drive(0, 0, 1, 0, 32'h400, 32'h10, 32'h2001);
      tick();
      check("jalr_pc", pc, 32'h2010);
      idle();
      tick(); tick();

      // JALR misaligned: 0x2002 -> trap
      drive(0, 0, 1, 0, 32'h5000, 32'h0, 32'h2002);
      tick();
      check("trap_set", {31'd0, misalign_trap}, 32'd1);
      check("trap_pc_v", trap_pc, 32'h5000);
      check("trap_pv", {31'd0, pc_valid}, 32'd0);
      check("trap_no_rd", {31'd0, redirect}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1'($urandom), 0, 1, $urandom & 32'hFFFF_FFFC, 32'h40, 32'h0);
         stall = 1'($urandom);
         tick();
      end
      check("trap_frozen_pc", pc, 32'h2018);

      // Reset mid-trap
      idle();
      rst = 1;
      tick();
      check("rst_trap_clr", {31'd0, misalign_trap}, 32'd0);
      rst = 0;
      tick(); tick();

      // Reset mid-flush
      drive(0, 1, 0, 0, 32'h40, 32'h100, 32'h0);
      tick();
      idle();
      rst = 1;
      tick();
      check("rst_flush_clr", {31'd0, flush}, 32'd0);
      check("rst_flush_pc", pc, RST_PC);
      rst = 0;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the program counter from the EX-stage control-flow resolution.
- Consumes the branch comparator's take_branch together with decoded jump/branch flags, computes the redirect target, and loads the PC.
- Flushes the younger IF/ID instructions for a fixed window after a redirect and halts fetch on a misaligned target.
- Keeps saturating branch statistics counters; sits between EX and the fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FLUSH_CYCLES, 2: cycles flush is held after a redirect; legal range 1..7.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode hazard; holds the PC, does not block a redirect.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_branch  in  1  conditional branch in EX.
- ex_is_jal  in  1  JAL in EX.
- ex_is_jalr  in  1  JALR in EX.
- take_branch  in  1  comparator result for EX, same cycle.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended immediate.
- ex_rs1_val  in  32  forwarded rs1 value, used by JALR.
- pc  out  32  fetch address.
- pc_valid  out  1  fetch request enable.
- flush  out  1  squash IF/ID and mark EX input invalid.
- redirect  out  1  one-cycle pulse; PC was just loaded from a target.
- redirect_target  out  32  target of the last redirect.
- misalign_trap  out  1  sticky trap flag.
- trap_pc  out  32  ex_pc of the faulting instruction.
- branch_count  out  CNT_W  resolved conditional branches.
- taken_count  out  CNT_W  taken conditional branches.

Behaviour:
- All outputs are registered.
- Reset values: pc=RESET_PC, pc_valid=0, flush=0, redirect=0, redirect_target=0, misalign_trap=0, trap_pc=0, both counters=0, state=BOOT, flush counter=0.
- Reset asserted mid-flush or mid-trap returns everything to these values on that edge.
- Target computation, all arithmetic mod 2^32:
  - JALR: (ex_rs1_val+ex_imm) with bit0 cleared.
  - JAL or branch: ex_pc+ex_imm.
  - Flag priority when several are set: jalr > jal > branch.
- req = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & take_branch)). req is evaluated only in RUN.
- Target is misaligned when target[1:0] != 0. This applies after the JALR bit0 clear, so a JALR traps only when bit1 is set.
- States:
  - BOOT: next edge sets pc_valid=1, pc stays RESET_PC, goes to RUN. Runs once per reset.
  - RUN, req with aligned target (stall ignored):
    - pc<=target, redirect<=1, redirect_target<=target, flush<=1.
    - Flush counter <= FLUSH_CYCLES-1, go to FLUSH. If FLUSH_CYCLES=1, go straight to RUN with flush cleared the following edge.
  - RUN, req with misaligned target:
    - misalign_trap<=1, trap_pc<=ex_pc, pc_valid<=0, pc held, go to TRAP. No redirect pulse.
  - RUN, no req: pc held if stall, else pc<=pc+4. redirect<=0, flush<=0.
  - FLUSH:
    - flush=1; EX inputs ignored, so a req here is a squashed instruction and is not counted.
    - pc<=pc+4 unless stall; stall does not extend the flush window.
    - Counter decrements; the edge where it reads 0 clears flush and returns to RUN.
    - Net effect: flush is high for exactly FLUSH_CYCLES cycles, starting the cycle redirect is high.
  - TRAP: all outputs frozen, inputs ignored, exit only via rst.
- Counters update in RUN only, saturating at all-ones:
  - branch_count +1 on ex_valid & ex_is_branch & !ex_is_jal & !ex_is_jalr.
  - taken_count +1 when that branch also has take_branch=1 and an aligned target. Misaligned taken branches are counted in branch_count only.
- pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.

Test Plan:
- Reset sequence: release rst, no stall -> pc_valid=0 in the first cycle, then pc=0 with pc_valid=1, then pc=4, then pc=8.
- Taken BEQ: ex_pc=0x100, imm=0x40, take_branch=1 -> next cycle pc=0x140, redirect=1 for 1 cycle, flush=1 for 2 cycles; branch_count=1, taken_count=1.
- Not-taken branch with stall=1 in the same cycle -> pc held, no flush, branch_count+1, taken_count unchanged.
- JALR: rs1=0x2001, imm=0x10 -> target 0x2010, redirect; second case rs1=0x2002, imm=0 -> misalign_trap=1, trap_pc=ex_pc, pc_valid=0, frozen until rst.
- Redirect during FLUSH: a second taken branch presented in the flush cycle -> ignored, pc keeps incrementing from the first target, counters unchanged.
- Saturation and wrap: preload counters at all-ones via a CNT_W=4 build, take branches -> counts stay 15; pc=0xFFFF_FFFC, no stall -> pc=0.
